// File: rtl/membus_arb.sv
`default_nettype none
// ============================================================================
// membus_arb : fixed-priority memory bus arbiter, read/write/read-modify-write
// Rev 1.0
// ============================================================================
module membus_arb #(
  parameter int NPORT = 4,
  parameter int TMO   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NPORT-1:0]     rq_cyc,
  input  logic [NPORT-1:0]     rd_rq,
  input  logic [NPORT-1:0]     wr_rq,
  input  logic [NPORT-1:0]     wr_rs,
  input  logic [15*NPORT-1:0]  ma,
  input  logic [36*NPORT-1:0]  mb_in,
  output logic [NPORT-1:0]     addr_ack,
  output logic [NPORT-1:0]     rd_rs,
  output logic [35:0]          mb_out,
  output logic                 core_rd,
  output logic                 core_wr,
  output logic [14:0]          core_addr,
  output logic [35:0]          core_wdata,
  input  logic [35:0]          core_rdata,
  input  logic                 core_done
);

  localparam int c_PW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int c_CW = $clog2(TMO + 1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_ACK    = 3'd1;
  localparam logic [2:0] c_RD     = 3'd2;
  localparam logic [2:0] c_WAITWR = 3'd3;
  localparam logic [2:0] c_WR     = 3'd4;
  localparam logic [2:0] c_REL    = 3'd5;

  logic [2:0]       r_state;
  logic [c_PW-1:0]  r_port;
  logic             r_rd;
  logic             r_wr;
  logic [14:0]      r_addr;
  logic [35:0]      r_wdata;
  logic [35:0]      r_mb_out;
  logic [NPORT-1:0] r_rd_rs;
  logic [c_CW-1:0]  r_cnt;

  logic [NPORT-1:0] w_valid;
  logic             w_gnt_found;
  logic [c_PW-1:0]  w_gnt_port;
  logic [NPORT-1:0] w_sel;
  logic [35:0]      w_mb_sel;
  logic             w_rq_own;
  logic             w_wrs_own;
  logic             w_timeout;

  // A cycle request without a read or write qualifier is not a request.
  assign w_valid = rq_cyc & (rd_rq | wr_rq);

  // Scan downward so the lowest-numbered valid port is the last one written.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_port  = '0;
    for (int i = NPORT - 1; i >= 0; i--) begin
      if (w_valid[i]) begin
        w_gnt_found = 1'b1;
        w_gnt_port  = c_PW'(i);
      end
    end
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NPORT; i++) begin
      w_sel[i] = (r_port == c_PW'(i));
    end
  end

  assign w_mb_sel  = mb_in[36*r_port +: 36];
  assign w_rq_own  = rq_cyc[r_port];
  assign w_wrs_own = wr_rs[r_port];
  assign w_timeout = (r_cnt == c_CW'(TMO - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= c_IDLE;
      r_port   <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_mb_out <= '0;
      r_rd_rs  <= '0;
      r_cnt    <= '0;
    end else begin
      r_rd_rs <= '0;
      case (r_state)
        c_IDLE: begin
          if (w_gnt_found) begin
            r_port  <= w_gnt_port;
            r_addr  <= ma[15*w_gnt_port +: 15];
            r_rd    <= rd_rq[w_gnt_port];
            r_wr    <= wr_rq[w_gnt_port];
            r_state <= c_ACK;
          end
        end
        c_ACK: begin
          if (r_rd) begin
            r_state <= c_RD;
          end else begin
            r_wdata <= w_mb_sel;
            r_state <= c_WR;
          end
        end
        c_RD: begin
          // Read data is also staged as write data so an abandoned RMW restores it.
          if (core_done) begin
            r_mb_out <= core_rdata;
            r_wdata  <= core_rdata;
            r_rd_rs  <= w_sel;
            r_cnt    <= '0;
            r_state  <= r_wr ? c_WAITWR : c_REL;
          end
        end
        c_WAITWR: begin
          if (w_wrs_own) begin
            r_wdata <= w_mb_sel;
            r_state <= c_WR;
          end else if (w_timeout || !w_rq_own) begin
            r_state <= c_WR;
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
        c_WR: begin
          if (core_done) begin
            r_state <= c_REL;
          end
        end
        c_REL: begin
          if (!w_rq_own) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign addr_ack   = (r_state == c_ACK) ? w_sel : '0;
  assign rd_rs      = r_rd_rs;
  assign mb_out     = r_mb_out;
  assign core_rd    = (r_state == c_RD);
  assign core_wr    = (r_state == c_WR);
  assign core_addr  = r_addr;
  assign core_wdata = r_wdata;

endmodule
`default_nettype wire

// File: doc/membus_arb.md
MEMBUS_ARB -- requirements
Module: membus_arb

Interface
REQ-001 SHALL have parameter NPORT, 4, number of memory bus ports; port 0 has highest priority.
REQ-002 SHALL have parameter TMO, 64, cycles allowed between rd_rs and wr_rs in a read-modify-write cycle.
REQ-003 SHALL have port clk  in  1  system clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port rq_cyc  in  NPORT  per-port cycle request, held for the whole cycle.
REQ-006 SHALL have port rd_rq  in  NPORT  per-port read request, qualifying rq_cyc.
REQ-007 SHALL have port wr_rq  in  NPORT  per-port write request; rd_rq and wr_rq together mean read-modify-write.
REQ-008 SHALL have port wr_rs  in  NPORT  per-port write-restart strobe, one cycle, data valid on mb_in.
REQ-009 SHALL have port ma  in  15*NPORT  per-port word address; port p occupies slice p.
REQ-010 SHALL have port mb_in  in  36*NPORT  per-port write data, bit 0 MSB per slice.
REQ-011 SHALL have port addr_ack  out  NPORT  one-cycle address-acknowledge pulse to the granted port.
REQ-012 SHALL have port rd_rs  out  NPORT  one-cycle read-restart pulse; mb_out valid in the same cycle.
REQ-013 SHALL have port mb_out  out  36  read data, held until the next read completes.
REQ-014 SHALL have port core_rd, core_wr  out  1 each  core access strobes, level, held until core_done.
REQ-015 SHALL have port core_addr  out  15 / core_wdata  out  36  latched address and write data.
REQ-016 SHALL have ports core_rdata  in  36 and core_done  in  1  (one-cycle completion pulse).

Function
REQ-017 SHALL implement states IDLE, ACK, RD, WAITWR, WR, REL.
REQ-018 IDLE: SHALL grant the lowest-numbered p with rq_cyc[p] & (rd_rq[p] | wr_rq[p]), latch ma[p], rd_rq[p] and wr_rq[p], and go to ACK; rq_cyc without rd_rq or wr_rq SHALL be ignored.
REQ-019 ACK: SHALL pulse addr_ack[p] for exactly one cycle; then RD if the read flag is set, otherwise latch mb_in[p] into core_wdata and go to WR.
REQ-020 RD: SHALL hold core_rd; on core_done latch core_rdata into mb_out and core_wdata, pulse rd_rs[p] in the following cycle, then go to WAITWR if the write flag is set, otherwise REL.
REQ-021 WAITWR: SHALL count cycles; on wr_rs[p], latch mb_in[p] into core_wdata and go to WR; wr_rs from other ports SHALL be ignored.
REQ-022 WAITWR: if the count reaches TMO or rq_cyc[p] drops, SHALL go to WR with the read data unchanged (restore), and the cycle SHALL be treated as aborted.
REQ-023 WAITWR: wr_rs[p] in the same cycle as timeout SHALL win; the new data is written.
REQ-024 WR: SHALL hold core_wr; on core_done go to REL.
REQ-025 REL: SHALL wait until rq_cyc[p] is low, then return to IDLE; no new grant is possible before this, and no grant SHALL occur in the same cycle.
REQ-026 Requests arriving during a cycle SHALL wait; priority SHALL be re-evaluated only in IDLE. Starvation of low ports is accepted.
REQ-027 core_rd and core_wr SHALL never be asserted together; core_addr SHALL be stable from ACK through WR.
REQ-028 Minimum latency rq_cyc -> addr_ack SHALL be 2 cycles from IDLE.
REQ-029 Pure read: IDLE -> ACK -> RD -> REL; pure write: IDLE -> ACK -> WR -> REL.

Reset
REQ-030 reset SHALL immediately force IDLE, with all outputs at 0, the counter at 0 and the latched flags cleared, including mid-cycle; a core access in progress is abandoned.
REQ-031 After reset deasserts, the first grant SHALL occur on the first clk edge where a valid request is present.

Verification
REQ-032 Port 2 read of address 0o1000, core_rdata=0o504554545700 -> addr_ack[2], then rd_rs[2] with mb_out=0o504554545700, back in IDLE after rq_cyc[2] drops.
REQ-033 Ports 1 and 3 request writes in the same cycle -> port 1 served first; port 3 receives addr_ack only after port 1 REL completes.
REQ-034 Port 0 RMW at 0o20, core_rdata=5, wr_rs[0] with mb_in=6 after 10 cycles -> core_wr with core_wdata=6.
REQ-035 Port 0 RMW with no wr_rs -> after TMO cycles, core_wr with core_wdata equal to the read data.
REQ-036 reset asserted while in RD with core_rd=1 -> core_rd=0 with no clock edge; following request served normally.
REQ-037 rq_cyc[1] with rd_rq=wr_rq=0 -> no addr_ack and no core strobe; port 2 valid request still granted.
